// File: rtl/panel_input.sv
// panel_input: PDP-8 front-panel switch register and pushbutton scanner.
// Synchronises, debounces and edge-detects SR switches and four buttons.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   sw_raw    raw SR toggle switches (bit 11 = SR0)
//   btn_raw   raw buttons: [0] load addr, [1] deposit, [2] examine, [3] run/stop
//   sr        debounced switch register
//   btn_level debounced button levels
//   btn_pulse one-clk strobe per debounced press (plus repeats, see below)
//   tick      one-clk scan tick, every 2^DIV_WIDTH clk
//
// Build option: define PANEL_AUTOREPEAT_EN to add held-button autorepeat
// (first repeat HOLD_TICKS ticks after the press, then every REPEAT_TICKS).

module panel_input #(
   parameter int DIV_WIDTH      = 11,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int HOLD_TICKS     = 64,
   parameter int REPEAT_TICKS   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] sw_raw,
   input  logic [3:0]  btn_raw,
   output logic [11:0] sr,
   output logic [3:0]  btn_level,
   output logic [3:0]  btn_pulse,
   output logic        tick
);

   localparam int CW = $clog2(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic [15:0]          sync1;
   logic [15:0]          sync2;
   logic [DIV_WIDTH-1:0] div;
   logic [15:0]          stable;
   logic [15:0]          stable_nxt;
   logic [CW-1:0]        cnt     [16];
   logic [CW-1:0]        cnt_nxt [16];
   logic [3:0]           btn_nxt;
   logic [3:0]           press;
   logic [3:0]           fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {btn_raw, sw_raw};
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) div <= '0;
      else       div <= div + DIV_WIDTH'(1);
   end

   assign tick = &div;

   // Any agreeing tick clears the count, so only an unbroken run of
   // DEBOUNCE_TICKS disagreeing samples moves the stable value.
   always_comb begin
      stable_nxt = stable;
      cnt_nxt    = cnt;
      for (int i = 0; i < 16; i++) begin
         if (tick) begin
            if (sync2[i] == stable[i]) begin
               cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable_nxt[i] = sync2[i];
               cnt_nxt[i]    = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= '0;
         for (int i = 0; i < 16; i++) cnt[i] <= '0;
      end else begin
         stable <= stable_nxt;
         for (int i = 0; i < 16; i++) cnt[i] <= cnt_nxt[i];
      end
   end

   assign sr        = stable[11:0];
   assign btn_level = stable[15:12];
   assign btn_nxt   = stable_nxt[15:12];

   // Rising edge taken from the next-state value so the strobe lines up
   // with the first cycle in which btn_level reads high.
   assign press = btn_nxt & ~btn_level;

`ifdef PANEL_AUTOREPEAT_EN
   localparam int RW = $clog2(HOLD_TICKS + 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] RELOAD    = RW'(HOLD_TICKS - REPEAT_TICKS);

   logic [RW-1:0] rep [4];
   logic [3:0]    rep_fire;

   // Reloading to HOLD-REPEAT after each fire gives the repeat period
   // without a modulo compare.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset || !btn_level[i]) begin
            rep[i] <= '0;
         end else if (tick) begin
            if (rep[i] == HOLD_LAST) rep[i] <= RELOAD;
            else                     rep[i] <= rep[i] + RW'(1);
         end
      end
   end

   // btn_nxt gate: a release landing on a repeat tick must not fire.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < 4; i++) begin
         rep_fire[i] = tick & btn_level[i] & btn_nxt[i]
                     & (rep[i] == HOLD_LAST);
      end
   end

   assign fire = press | rep_fire;
`else
   assign fire = press;
`endif

   always_ff @(posedge clk) begin
      if (reset) btn_pulse <= '0;
      else       btn_pulse <= fire;
   end

endmodule

// File: doc/panel_input.md
Name: panel_input

Overview:
- Front-panel input scanner for the PDP-8 console. It is the input-side counterpart of the LED/seven-segment output driver.
- Synchronises and debounces the 12-bit switch register (SR) and four momentary pushbuttons, using a shared slow scan tick.
- Presents stable switch levels, stable button levels and single-cycle press strobes to the CPU front-panel control logic (load address, deposit, examine, run/stop).

Parameters:
DIV_WIDTH, 11, width of the free-running tick divider; one scan tick every 2^DIV_WIDTH clk cycles
DEBOUNCE_TICKS, 4, consecutive ticks (2..15) an input must disagree with its stable value before the stable value changes
HOLD_TICKS, 64, autorepeat initial delay in ticks (used only with the optional feature)
REPEAT_TICKS, 16, autorepeat period in ticks (used only with the optional feature)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
sw_raw  input  12  raw SR toggle switches, asynchronous, bit 11 = SR0 (MSB)
btn_raw  input  4  raw pushbuttons, asynchronous, active high; [0]=load addr, [1]=deposit, [2]=examine, [3]=run/stop
sr  output  12  debounced switch register value
btn_level  output  4  debounced button levels
btn_pulse  output  4  one-clk strobe per debounced press
tick  output  1  one-clk scan tick, exported for the display scanner/test

Behaviour:
- Every input bit (16 total) passes through a two-flop synchroniser before any other use.
- Divider:
  - DIV_WIDTH-bit up-counter that wraps naturally.
  - tick = 1 for exactly the one cycle where divider == all ones.
- Per-bit debounce state: stable bit plus a counter of width ceil(log2(DEBOUNCE_TICKS)). On a clk edge with tick = 1:
  - synchronised sample == stable: counter <= 0.
  - sample != stable and counter == DEBOUNCE_TICKS-1: stable <= sample, counter <= 0.
  - otherwise: counter <= counter+1.
- Counters do not change on cycles where tick = 0.
- Glitch rejection: a bounce shorter than DEBOUNCE_TICKS ticks is fully rejected, because any agreeing tick clears the counter.
- sr = stable bits for the switches; btn_level = stable bits for the buttons.
- btn_pulse[i]:
  - Registered; equals 1 in the cycle immediately after the edge at which btn_level[i] changes 0->1, and 0 otherwise.
  - Never asserted on release.
  - Several bits may pulse in the same cycle if their buttons debounce on the same tick. No priority among them.
- Latency: from a raw change held stable to the output change is 2 clk (synchroniser) plus DEBOUNCE_TICKS ticks, with up to one tick period of alignment.
- Reset:
  - Divider = 0; synchronisers, stable bits and counters = 0.
  - sr = 0, btn_level = 0, btn_pulse = 0, tick = 0.
  - Reset asserted mid-debounce discards the partial count.
  - After reset, switches that are held high reach sr after DEBOUNCE_TICKS ticks. A button already held at reset produces one press pulse once it debounces.
- Simultaneous events: a sample that disagrees while the counter is at its terminal value updates stable on that tick. Reset overrides tick.

Optional Feature:
Macro PANEL_AUTOREPEAT_EN.
- Defined:
  - Each button has a repeat counter, cleared whenever btn_level[i] = 0.
  - While btn_level[i] = 1, the counter increments on each tick.
  - When the count reaches HOLD_TICKS, and every REPEAT_TICKS ticks after that, btn_pulse[i] asserts for one cycle after the tick edge.
  - Release stops repeats immediately. Reset clears the repeat counters.
- Not defined: no repeat logic is present; exactly one pulse per debounced press; HOLD_TICKS and REPEAT_TICKS are ignored.

Test Plan:
All scenarios use DIV_WIDTH=3 (tick every 8 clk) and DEBOUNCE_TICKS=4 unless stated.
- Reset, then sw_raw=12'o5252 held -> sr stays 0 for the first 3 ticks and reads 12'o5252 after the 4th tick; tick period is exactly 8 clk.
- btn_raw[1] toggles 1/0 every 5 clk for 40 clk, then held 1 -> no pulse during the bouncing; btn_level[1] rises 4 ticks after the hold starts; btn_pulse[1] high for exactly 1 clk; no pulse on release.
- btn_raw[0] and btn_raw[2] rise in the same clk -> btn_pulse = 4'b0101 in a single cycle.
- sr=12'o7777 stable, then sw_raw[0] drops for 3 ticks and returns -> sr unchanged.
- Reset asserted for 1 clk when a bit's counter is at 2 -> all outputs 0 next cycle; re-debounce requires the full 4 ticks.
- With PANEL_AUTOREPEAT_EN, HOLD_TICKS=8, REPEAT_TICKS=2, btn_raw[3] held for 20 ticks after it debounces -> press pulse, then pulses at 8, 10, 12, 14, 16, 18 ticks after the level rise; none after release. Without the macro -> exactly one pulse.
